// File: rtl/sq_pkg.sv
// Shared constants, types and a reference squaring function for the pipelined squarer.
// Build option SQUARE_ADDEND_EN widens the accumulator by one carry bit.
package sq_pkg;
    localparam int SQ_W      = 24;
    localparam int SQ_STAGES = 8;
    localparam int SQ_BPS    = SQ_W / SQ_STAGES;

`ifdef SQUARE_ADDEND_EN
    // Extra accumulator bit holds the carry out of ain^2 + addend.
    localparam int SQ_CARRY = 1;
`else
    localparam int SQ_CARRY = 0;
`endif

    typedef logic [SQ_W-1:0]   sq_op_t;
    typedef logic [2*SQ_W-1:0] sq_res_t;

    function automatic sq_res_t sq_ref(input sq_op_t op);
        sq_res_t wide;
        wide = sq_res_t'(op);
        return wide * wide;
    endfunction
endpackage

// File: rtl/sq_stage.sv
// One squarer pipeline stage: adds the partial products for BPS operand bits
// (bits K*BPS .. K*BPS+BPS-1) onto the incoming accumulator and registers the result.
module sq_stage
    import sq_pkg::*;
#(
    parameter int W   = SQ_W,
    parameter int BPS = SQ_BPS,
    parameter int K   = 0,
    parameter int AW  = 2*SQ_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [W-1:0]  a_in,
    input  logic [AW-1:0] acc_in,
    input  logic          v_in,
    output logic [W-1:0]  a_out,
    output logic [AW-1:0] acc_out,
    output logic          v_out
);
    logic [AW-1:0] a_wide;
    logic [AW-1:0] acc_next;

    always_comb begin
        a_wide   = AW'(a_in);
        acc_next = acc_in;
        for (int j = K*BPS; j < K*BPS + BPS; j++) begin
            if (a_in[j]) begin
                acc_next = acc_next + (a_wide << j);
            end
        end
    end

    // Datapath is cleared too so nothing undefined ever reaches out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_out   <= '0;
            acc_out <= '0;
            v_out   <= 1'b0;
        end else if (en) begin
            a_out   <= a_in;
            acc_out <= acc_next;
            v_out   <= v_in;
        end
    end
endmodule

// File: rtl/square_u24_8.sv
// Pipelined unsigned squarer, out = ain*ain, latency STAGES enabled edges.
// Define SQUARE_ADDEND_EN to add an addend to the square and expose the carry on ovf.
module square_u24_8
    import sq_pkg::*;
#(
    parameter int W      = SQ_W,
    parameter int STAGES = SQ_STAGES
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   ain,
    input  logic           vldin,
    input  logic           en,
`ifdef SQUARE_ADDEND_EN
    input  logic [2*W-1:0] addend,
    output logic           ovf,
`endif
    output logic [2*W-1:0] out,
    output logic           vldout
);
    localparam int BPS = W / STAGES;
    localparam int AW  = 2*W + SQ_CARRY;

    if (W % STAGES != 0) begin : g_bad_split
        $error("square_u24_8: W must be a multiple of STAGES");
    end

    logic [W-1:0]  a_pipe   [STAGES];
    logic [AW-1:0] acc_pipe [STAGES];
    logic          v_pipe   [STAGES];
    logic [AW-1:0] acc_init;
    logic [W-1:0]  unused_a;

`ifdef SQUARE_ADDEND_EN
    assign acc_init = AW'(addend);
`else
    assign acc_init = '0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            sq_stage #(.W(W), .BPS(BPS), .K(k), .AW(AW)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .a_in    (ain),
                .acc_in  (acc_init),
                .v_in    (vldin),
                .a_out   (a_pipe[k]),
                .acc_out (acc_pipe[k]),
                .v_out   (v_pipe[k])
            );
        end else begin : g_next
            sq_stage #(.W(W), .BPS(BPS), .K(k), .AW(AW)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .a_in    (a_pipe[k-1]),
                .acc_in  (acc_pipe[k-1]),
                .v_in    (v_pipe[k-1]),
                .a_out   (a_pipe[k]),
                .acc_out (acc_pipe[k]),
                .v_out   (v_pipe[k])
            );
        end
    end

    // The operand copy leaving the last stage has no consumer.
    assign unused_a = a_pipe[STAGES-1];
    assign out      = acc_pipe[STAGES-1][2*W-1:0];
    assign vldout   = v_pipe[STAGES-1];
`ifdef SQUARE_ADDEND_EN
    assign ovf      = acc_pipe[STAGES-1][2*W];
`endif
endmodule

// File: tb/tb_square_u24_8.sv
// Directed self-checking bench for square_u24_8 with a shift-register model of the pipeline.
// Exercises the SQUARE_ADDEND_EN build as well when that macro is defined.
module tb_square_u24_8;
    import sq_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    sq_op_t  ain;
    logic    vldin;
    logic    en;
    sq_res_t out;
    logic    vldout;
`ifdef SQUARE_ADDEND_EN
    sq_res_t addend;
    logic    ovf;
`endif

    int total = 0;
    int bad   = 0;

    sq_res_t m_out [SQ_STAGES];
    logic    m_v   [SQ_STAGES];
    logic    m_ovf [SQ_STAGES];

    always #5 clk = ~clk;

    square_u24_8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ain    (ain),
        .vldin  (vldin),
        .en     (en),
`ifdef SQUARE_ADDEND_EN
        .addend (addend),
        .ovf    (ovf),
`endif
        .out    (out),
        .vldout (vldout)
    );

    // One clock: drive inputs, advance the model exactly as the pipeline should, then check.
    task automatic step(input sq_op_t a, input logic v, input logic e,
                        input sq_res_t exp, input logic exp_ovf);
        logic was_reset;
        ain   = a;
        vldin = v;
        en    = e;
        @(posedge clk);
        was_reset = !rst_n;
        if (was_reset) begin
            for (int i = 0; i < SQ_STAGES; i++) begin
                m_out[i] = '0;
                m_v[i]   = 1'b0;
                m_ovf[i] = 1'b0;
            end
        end else if (e) begin
            for (int i = SQ_STAGES-1; i > 0; i--) begin
                m_out[i] = m_out[i-1];
                m_v[i]   = m_v[i-1];
                m_ovf[i] = m_ovf[i-1];
            end
            m_out[0] = exp;
            m_v[0]   = v;
            m_ovf[0] = exp_ovf;
        end
        #1;
        total++;
        assert (vldout === m_v[SQ_STAGES-1]) else begin
            bad++;
            $error("[TB] FAIL vldout got=%0b want=%0b", vldout, m_v[SQ_STAGES-1]);
        end
        if (was_reset || m_v[SQ_STAGES-1]) begin
            total++;
            assert (out === m_out[SQ_STAGES-1]) else begin
                bad++;
                $error("[TB] FAIL out got=%h want=%h", out, m_out[SQ_STAGES-1]);
            end
`ifdef SQUARE_ADDEND_EN
            total++;
            assert (ovf === m_ovf[SQ_STAGES-1]) else begin
                bad++;
                $error("[TB] FAIL ovf got=%0b want=%0b", ovf, m_ovf[SQ_STAGES-1]);
            end
`endif
        end
    endtask

    task automatic drain();
        for (int i = 0; i < SQ_STAGES; i++) step('0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    initial begin
        sq_op_t ra;
        logic   re;
        logic   rv;
        rst_n = 1'b0;
`ifdef SQUARE_ADDEND_EN
        addend = '0;
`endif
        // Reset state, with en=1 to show reset wins.
        step(24'h123456, 1'b1, 1'b1, '0, 1'b0);
        step(24'h123456, 1'b1, 1'b1, '0, 1'b0);
        rst_n = 1'b1;

        // Zero operand; model demands vldout exactly on the 8th enabled edge.
        step(24'h000000, 1'b1, 1'b1, 48'h0, 1'b0);
        drain();

        // Extremes of the operand range.
        step(24'hFFFFFF, 1'b1, 1'b1, 48'hFFFFFE000001, 1'b0);
        step(24'h800000, 1'b1, 1'b1, 48'h400000000000, 1'b0);
        step(24'h000001, 1'b1, 1'b1, 48'h000000000001, 1'b0);
        step(24'h001000, 1'b1, 1'b1, 48'h000001000000, 1'b0);
        drain();

        // Back-to-back stream 1..100 with en held high.
        for (int i = 1; i <= 100; i++) begin
            step(sq_op_t'(i), 1'b1, 1'b1, sq_res_t'(i * i), 1'b0);
        end
        drain();

        // Random operands with en and vldin toggling.
        for (int i = 0; i < 120; i++) begin
            ra = sq_op_t'($urandom);
            re = ($urandom_range(0, 3) != 0);
            rv = ($urandom_range(0, 4) != 0);
            step(ra, rv, re, sq_ref(ra), 1'b0);
        end
        for (int i = 0; i < 6; i++) step('0, 1'b0, 1'b0, '0, 1'b0);
        drain();

        // Reset with five items in flight discards them all.
        step(24'h000003, 1'b1, 1'b1, 48'h9, 1'b0);
        step(24'h000005, 1'b1, 1'b1, 48'h19, 1'b0);
        step(24'h000007, 1'b1, 1'b1, 48'h31, 1'b0);
        step(24'h00000B, 1'b1, 1'b1, 48'h79, 1'b0);
        step(24'h00000D, 1'b1, 1'b1, 48'hA9, 1'b0);
        rst_n = 1'b0;
        step(24'h00000F, 1'b1, 1'b1, 48'hE1, 1'b0);
        rst_n = 1'b1;
        step(24'h000010, 1'b1, 1'b1, 48'h100, 1'b0);
        drain();

`ifdef SQUARE_ADDEND_EN
        addend = 48'h1FFFFFE;
        step(24'hFFFFFF, 1'b1, 1'b1, 48'hFFFFFFFFFFFF, 1'b0);
        addend = 48'h1FFFFFF;
        step(24'hFFFFFF, 1'b1, 1'b1, 48'h000000000000, 1'b1);
        addend = 48'h5;
        step(24'h000003, 1'b1, 1'b1, 48'h00000000000E, 1'b0);
        addend = '0;
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
